// File: rtl/epc_linerx_if.sv
// rtl/epc_linerx_if.sv - bit-decoder-to-receiver handshake and result bus for epc_linerx
interface epc_linerx_if #(parameter int NDATA = 112);
    logic             start;
    logic             bitin;
    logic             bitvalid;
    logic [NDATA-1:0] epcword;
    logic             busy;
    logic             epcdone;
    logic             crcok;
    logic             lenok;
    logic             overrun;

    modport master (
        output start, bitin, bitvalid,
        input  epcword, busy, epcdone, crcok, lenok, overrun
    );

    modport slave (
        input  start, bitin, bitvalid,
        output epcword, busy, epcdone, crcok, lenok, overrun
    );
endinterface

// File: rtl/epc_linerx.sv
// rtl/epc_linerx.sv - PC+EPC backscatter frame receiver with CRC-16 and PC length check
module epc_linerx #(
    parameter int NDATA     = 112,
    parameter int CRC_EN    = 1,
    parameter int EPC_WORDS = 6
) (
    input  logic          epcclk,
    input  logic          reset,
    epc_linerx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    state_t           state_q;
    logic [6:0]       cnt_q;
    logic [NDATA-1:0] word_q, word_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      rxcrc_q, rxcrc_d;
    logic             busy_q, done_q, crcok_q, lenok_q, overrun_q;

    always_comb begin
        word_d  = {word_q[NDATA-2:0], bus.bitin};
        acc_d   = {acc_q[14:0], 1'b0} ^ ((acc_q[15] ^ bus.bitin) ? 16'h1021 : 16'h0000);
        rxcrc_d = {rxcrc_q[14:0], bus.bitin};
    end

    // start overrides everything, including a bitvalid in the same cycle
    always_ff @(posedge epcclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            word_q    <= '0;
            acc_q     <= '0;
            rxcrc_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crcok_q   <= 1'b0;
            lenok_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (bus.start) begin
            state_q   <= DATA;
            cnt_q     <= 7'(NDATA - 1);
            word_q    <= '0;
            acc_q     <= 16'hFFFF;
            rxcrc_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            crcok_q   <= 1'b0;
            lenok_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (bus.bitvalid) begin
            case (state_q)
                DATA: begin
                    word_q <= word_d;
                    acc_q  <= acc_d;
                    if (cnt_q == 7'd0) begin
                        if (CRC_EN != 0) begin
                            state_q <= CRC;
                            cnt_q   <= 7'd15;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            crcok_q <= 1'b1;
                            lenok_q <= (word_d[NDATA-1 -: 5] == 5'(EPC_WORDS));
                        end
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                CRC: begin
                    rxcrc_q <= rxcrc_d;
                    if (cnt_q == 7'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        crcok_q <= (rxcrc_d == ~acc_q);
                        lenok_q <= (word_q[NDATA-1 -: 5] == 5'(EPC_WORDS));
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                DONE:    overrun_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.epcword = word_q;
    assign bus.busy    = busy_q;
    assign bus.epcdone = done_q;
    assign bus.crcok   = crcok_q;
    assign bus.lenok   = lenok_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_epc_linerx.sv
// tb/tb_epc_linerx.sv - scoreboard bench for epc_linerx with CRC and no-CRC instances
module tb_epc_linerx;
    logic epcclk = 1'b0;
    logic reset  = 1'b1;
    always #5 epcclk = ~epcclk;

    epc_linerx_if #(.NDATA(112)) b0 ();
    epc_linerx_if #(.NDATA(112)) b1 ();

    epc_linerx #(.NDATA(112), .CRC_EN(1), .EPC_WORDS(6)) u0 (.epcclk(epcclk), .reset(reset), .bus(b0.slave));
    epc_linerx #(.NDATA(112), .CRC_EN(0), .EPC_WORDS(6)) u1 (.epcclk(epcclk), .reset(reset), .bus(b1.slave));

    typedef struct {
        logic [111:0] word;
        logic         crcok;
        logic         lenok;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic [111:0] gold;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ~CRC-16/CCITT, preset FFFF, computed as a plain polynomial division over the data
    function automatic logic [15:0] model_crc(input logic [111:0] d);
        logic [15:0] r = 16'hFFFF;
        for (int i = 111; i >= 0; i--)
            r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
        return ~r;
    endfunction

    task automatic drive(input int sel, input logic st, input logic vb, input logic b);
        if (sel == 0) begin b0.start = st; b0.bitvalid = vb; b0.bitin = b; end
        else          begin b1.start = st; b1.bitvalid = vb; b1.bitin = b; end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? b0.epcdone : b1.epcdone;
    endfunction

    task automatic send_bit(input int sel, input logic b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) @(negedge epcclk);
        drive(sel, 1'b0, 1'b1, b);
        @(negedge epcclk);
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start(input int sel, input logic with_bit);
        drive(sel, 1'b1, with_bit, 1'b1);
        @(negedge epcclk);
        drive(sel, 1'b0, 1'b0, 1'b0);
        check("busy_after_start", (sel == 0) ? b0.busy : b1.busy, 1);
    endtask

    task automatic send_frame(input int sel, input logic [111:0] d, input logic [15:0] flip,
                              input int maxgap, input logic coinc);
        logic [15:0] crc;
        exp_t        e;
        logic        crcen;
        crcen   = (sel == 0);
        crc     = model_crc(d) ^ flip;
        e.word  = d;
        e.crcok = !crcen || (flip == 16'h0);
        e.lenok = (d[111:107] == 5'd6);
        pulse_start(sel, coinc);
        for (int i = 111; i >= 0; i--) begin
            if (i == 0 && !crcen) begin
                check("done_early", get_done(sel), 0);
                q1.push_back(e);
            end
            send_bit(sel, d[i], maxgap);
        end
        if (crcen) begin
            for (int i = 15; i >= 0; i--) begin
                if (i == 0) begin
                    check("done_early", get_done(sel), 0);
                    q0.push_back(e);
                end
                send_bit(sel, crc[i], maxgap);
            end
        end
        check("done_on_last_bit", get_done(sel), 1);
    endtask

    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge epcclk) begin
        exp_t e;
        if (b0.epcdone && !prev0) begin
            if (q0.size() == 0) check("unexpected_done0", 1, 0);
            else begin
                e = q0.pop_front();
                check("word0", b0.epcword, e.word);
                check("crcok0", b0.crcok, e.crcok);
                check("lenok0", b0.lenok, e.lenok);
                check("busy0_done", b0.busy, 0);
            end
        end
        if (b1.epcdone && !prev1) begin
            if (q1.size() == 0) check("unexpected_done1", 1, 0);
            else begin
                e = q1.pop_front();
                check("word1", b1.epcword, e.word);
                check("crcok1", b1.crcok, e.crcok);
                check("lenok1", b1.lenok, e.lenok);
                check("busy1_done", b1.busy, 0);
            end
        end
        prev0 = b0.epcdone;
        prev1 = b1.epcdone;
    end

    task automatic check_zero(input string name);
        check(name, {b0.epcword, b0.busy, b0.epcdone, b0.crcok, b0.lenok, b0.overrun}, 0);
    endtask

    initial begin
        gold = 112'h3000aabbccddeeff012345678910;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (2) @(negedge epcclk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge epcclk);

        send_frame(0, gold, 16'h0000, 0, 1'b0);
        send_frame(0, gold, 16'h0001, 0, 1'b0);
        send_frame(0, {16'h2800, gold[95:0]}, 16'h0000, 0, 1'b0);
        send_frame(0, gold, 16'h0000, 5, 1'b0);

        pulse_start(0, 1'b0);
        for (int i = 111; i > 51; i--) send_bit(0, gold[i], 0);
        reset = 1'b1;
        #1;
        check_zero("async_reset_mid_frame");
        @(negedge epcclk);
        check_zero("reset_held");
        reset = 1'b0;
        send_frame(0, gold, 16'h0000, 2, 1'b0);

        pulse_start(0, 1'b0);
        for (int i = 111; i > 51; i--) send_bit(0, ~gold[i], 0);
        send_frame(0, gold, 16'h0000, 0, 1'b0);

        for (int k = 0; k < 3; k++) send_bit(0, 1'($urandom), 0);
        check("overrun_set", b0.overrun, 1);
        check("word_held", b0.epcword, gold);
        check("done_held", b0.epcdone, 1);
        check("crcok_held", b0.crcok, 1);
        pulse_start(0, 1'b0);
        check("overrun_cleared", b0.overrun, 0);
        check("done_cleared", b0.epcdone, 0);

        send_frame(0, gold, 16'h0000, 0, 1'b1);

        for (int k = 0; k < 2; k++) begin
            logic [111:0] r;
            r = {16'h3000 | 16'($urandom_range(2047, 0)), 32'($urandom), 32'($urandom), 32'($urandom)};
            if (k == 1) r[111:107] = 5'($urandom);
            send_frame(0, r, (k == 1) ? 16'(1 << $urandom_range(15, 0)) : 16'h0, 3, 1'b0);
        end

        send_frame(1, gold, 16'h0000, 0, 1'b0);
        send_frame(1, {16'h2800, gold[95:0]}, 16'h0000, 1, 1'b0);

        repeat (3) @(negedge epcclk);
        check("queue0_drained", 32'(q0.size()), 0);
        check("queue1_drained", 32'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/epc_linerx.md
# epc_linerx

Reader-side receiver for the tag's PC+EPC backscatter reply. Samples a serial bitstream MSB first on `epcclk`, assembles the 16-bit PC and 96-bit EPC into a 112-bit word, and captures and checks the trailing CRC-16. It also validates the PC length field. It sits between the reader's bit decoder and the inventory controller, consuming exactly the frame the tag's EPC generator emits.

## Interface
- `NDATA`, 112: PC+EPC bits per frame (PC = top 16 bits).
- `CRC_EN`, 1: 1 = expect 16 CRC bits after data; 0 = frame ends after data.
- `EPC_WORDS`, 6: expected value of PC[15:11], the EPC length in 16-bit words.

Ports:
- `epcclk`  in  1  receive clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  single-cycle pulse; arms the receiver for a new frame.
- `bitin`  in  1  received data bit.
- `bitvalid`  in  1  `bitin` is sampled on this edge.
- `epcword`  out  NDATA  assembled PC+EPC; MSB is the first bit received.
- `busy`  out  1  high in DATA and CRC states.
- `epcdone`  out  1  frame complete; held high until `start` or `reset`.
- `crcok`  out  1  CRC match; meaningful only while `epcdone`=1.
- `lenok`  out  1  PC[15:11]==EPC_WORDS; meaningful only while `epcdone`=1.
- `overrun`  out  1  sticky; a valid bit arrived while in DONE.

## Operation
- States: IDLE, DATA, CRC, DONE. Reset → IDLE.
- `start`, from any state → DATA. On entry: bit counter = NDATA-1, `epcword` = 0, CRC accumulator = 16'hFFFF, received-CRC register = 0, `overrun` = 0, `epcdone` = 0.
- In DATA, each `bitvalid` cycle:
  - shift `epcword` left and insert `bitin` at the LSB;
  - update the CRC: fb = acc[15]^bitin; acc = {acc[14:0],0} ^ (fb ? 16'h1021 : 0);
  - decrement the counter.
- Exit from DATA, on the bit sampled when the counter is 0:
  - CRC_EN=1: go to CRC and set the counter to 15;
  - CRC_EN=0: go to DONE.
- In CRC, each `bitvalid` cycle shifts `bitin` into the received-CRC register, MSB first, and decrements the counter. The bit sampled at counter 0 → DONE.
- In DONE:
  - `crcok` = (rx_crc == ~acc). If CRC_EN=0, `crcok` is forced to 1.
  - `lenok` = (epcword[NDATA-1:NDATA-5] == EPC_WORDS).
  - `epcword` is held.
- Cycles with `bitvalid`=0 in DATA/CRC cause no change. There is no timeout; the inventory controller aborts a frame via `start` or `reset`.
- `bitvalid` in IDLE is ignored. `bitvalid` in DONE sets `overrun`; data and flags are unchanged.
- `start` and `bitvalid` in the same cycle: `start` wins and that bit is discarded.
- The counter is 7 bits wide and never wraps. Transitions occur at 0, so no underflow is possible.

## Timing
- All outputs are registered. Reset values: `epcword`=0, `busy`=0, `epcdone`=0, `crcok`=0, `lenok`=0, `overrun`=0.
- `busy` rises on the edge that samples `start`.
- `epcdone`, `crcok` and `lenok` become valid on the same edge that samples the final bit: bit NDATA+16 for CRC_EN=1, bit NDATA for CRC_EN=0. `busy` falls on that same edge.
- With `start` at cycle 0 and `bitvalid` continuous from cycle 1 (CRC_EN=1), `epcdone` is high after the edge of cycle 128.
- Reset mid-frame: outputs clear immediately (asynchronously) and the state returns to IDLE. Any partial frame is lost.

## Test plan
- Golden frame: `start`, then 112 bits of 112'h3000aabbccddeeff012345678910 MSB first, then the bench-model CRC (~CRC-16/CCITT, preset FFFF, over the 112 bits), with `bitvalid` continuous → `epcdone`=1 after 128 bits, `epcword` matches, `crcok`=1, `lenok`=1, `busy`=0.
- Same frame with CRC bit 0 inverted → `epcdone`=1, `crcok`=0, `lenok`=1. Same frame with PC 16'h2800 and its correct CRC → `crcok`=1, `lenok`=0.
- Same golden frame with random `bitvalid` gaps of 0–5 cycles → identical results, and `epcdone` rises on the edge of the 128th valid bit.
- Assert `reset` after 60 bits, then deassert and `start` again with the golden frame → all outputs 0 during reset, then a correct frame with `crcok`=1. Separately, `start` after 60 bits with no reset → the frame restarts cleanly.
- Three extra valid bits after DONE → `overrun`=1 and `epcword` unchanged. Next `start` → `overrun`=0 and `epcdone`=0. `start` coincident with `bitvalid` → that bit is not counted.
- CRC_EN=0 with the golden 112 bits → `epcdone` after 112 bits, `crcok`=1, `lenok`=1.
